can_tx_sequencer: RTL

- Bus initiator that drives the CAN controller's 32-bit register interface on behalf of a hardware client.
- Accepts one frame per valid/ready handshake, writes the ID, data and control registers, then raises the TX strobe.
- Polls the status register until the transmission ends, retries on lost arbitration, and returns a one-cycle result.
- Sits between a frame source (DMA or a test pattern engine) and the CAN controller instance, in place of CPU writes.

---
 rtl/can_tx_sequencer_pkg.sv | 7 +
 rtl/can_tx_sequencer_if.sv | 25 ++
 rtl/can_tx_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/can_tx_sequencer_pkg.sv
// can_pkg: register map, status bit positions and sequencer states for can_tx_sequencer
package can_pkg;
   localparam logic [1:0] REG_ID = 2'd0, REG_CTL = 2'd1, REG_DATA0 = 2'd2, REG_DATA1 = 2'd3;
   localparam int RTS_B = 8, LOST_B = 9, BITF_B = 10, ACK_B = 11;
   localparam int STROBE_B = 8;
   typedef enum logic [3:0] {IDLE, WR_ID, WR_D0, WR_D1, WR_CTL, SETTLE, POLL, RESULT, DRAIN} state_t;
endpackage

// File: rtl/can_tx_sequencer_if.sv
// can_tx_sequencer_if: frame request, controller register bus and result signals
interface can_tx_sequencer_if #(parameter int RW = 2);
   logic        req_valid, req_ready, req_ext, req_rtr;
   logic [28:0] req_id;
   logic [3:0]  req_dlc;
   logic [63:0] req_data;
   logic [9:0]  cfg_bauddiv;
   logic [2:0]  cfg_irqen;
   logic        bus_cs;
   logic [1:0]  bus_rs;
   logic [3:0]  bus_bytesel;
   logic [31:0] bus_d, bus_q;
   logic        res_valid, res_ack, res_lost, res_biterr, res_timeout, busy;
   logic [RW-1:0] res_retries;
   modport master (
      input  req_valid, req_id, req_ext, req_rtr, req_dlc, req_data, cfg_bauddiv, cfg_irqen, bus_q,
      output req_ready, bus_cs, bus_rs, bus_bytesel, bus_d,
      output res_valid, res_ack, res_lost, res_biterr, res_timeout, res_retries, busy
   );
   modport slave (
      output req_valid, req_id, req_ext, req_rtr, req_dlc, req_data, cfg_bauddiv, cfg_irqen, bus_q,
      input  req_ready, bus_cs, bus_rs, bus_bytesel, bus_d,
      input  res_valid, res_ack, res_lost, res_biterr, res_timeout, res_retries, busy
   );
endinterface

// File: rtl/can_tx_sequencer.sv
// can_tx_sequencer: writes a frame into the CAN controller, polls for completion, retries lost arbitration
module can_tx_sequencer
   import can_pkg::*;
#(
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 65535,
   parameter int RW        = 2
) (
   input logic clk,
   input logic reset,
   can_tx_sequencer_if.master io
);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t state, state_n;
   logic [28:0] id;
   logic ext, rtr, ack, lost, bitf, tmo;
   logic [3:0] dlc;
   logic [63:0] data;
   logic [RW-1:0] retries;
   logic [TW-1:0] tcnt;
   logic [31:0] ctl;
   logic accept, rts, retry, expire, wr, unused_q;
   assign accept = io.req_valid && state == IDLE;
   assign rts    = io.bus_q[RTS_B];
   assign retry  = state == POLL && !rts && io.bus_q[LOST_B] && retries < RW'(MAX_RETRY);
   assign expire = state == POLL && rts && tcnt == TW'(TIMEOUT - 1);
   assign unused_q = ^{io.bus_q[31:12], io.bus_q[7:0]};
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = io.req_valid ? WR_ID : IDLE;
         WR_ID:   state_n = rtr || dlc == 4'd0 ? WR_CTL : WR_D0;
         WR_D0:   state_n = dlc > 4'd4 ? WR_D1 : WR_CTL;
         WR_D1:   state_n = WR_CTL;
         WR_CTL:  state_n = SETTLE;
         SETTLE:  state_n = POLL;
         POLL:    state_n = retry ? WR_ID : (!rts || expire) ? RESULT : POLL;
         RESULT:  state_n = tmo ? DRAIN : IDLE;
         DRAIN:   state_n = rts ? DRAIN : IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         id      <= '0;
         ext     <= 1'b0;
         rtr     <= 1'b0;
         dlc     <= '0;
         data    <= '0;
         retries <= '0;
         tcnt    <= '0;
         ack     <= 1'b0;
         lost    <= 1'b0;
         bitf    <= 1'b0;
         tmo     <= 1'b0;
      end else begin
         if (accept) begin
            id      <= io.req_ext ? io.req_id : {18'b0, io.req_id[10:0]};
            ext     <= io.req_ext;
            rtr     <= io.req_rtr;
            dlc     <= io.req_dlc > 4'd8 ? 4'd8 : io.req_dlc;
            data    <= io.req_data;
            retries <= '0;
            tcnt    <= '0;
         end
         if (retry) begin
            retries <= retries + RW'(1);
            tcnt    <= '0;
         end else if (state == POLL) tcnt <= tcnt + TW'(1);
         if (state == POLL && state_n == RESULT) begin
            ack  <= !rts && io.bus_q[ACK_B];
            lost <= !rts && io.bus_q[LOST_B];
            bitf <= !rts && io.bus_q[BITF_B];
            tmo  <= rts;
         end
      end
   always_comb begin
      ctl = {io.cfg_irqen, 3'b0, io.cfg_bauddiv, 16'b0};
      ctl[STROBE_B] = 1'b1;
      ctl[3:0] = dlc;
   end
   assign wr             = state inside {WR_ID, WR_D0, WR_D1, WR_CTL};
   assign io.bus_cs      = wr || state inside {POLL, DRAIN};
   assign io.bus_bytesel = wr ? 4'hF : 4'h0;
   assign io.bus_rs      = state == WR_D0 ? REG_DATA0 : state == WR_D1 ? REG_DATA1 :
                           state inside {WR_CTL, POLL, DRAIN} ? REG_CTL : REG_ID;
   assign io.bus_d       = state == WR_ID ? {ext, rtr, 1'b0, id} : state == WR_D0 ? data[31:0] :
                           state == WR_D1 ? data[63:32] : state == WR_CTL ? ctl : 32'h0;
   assign io.req_ready   = state == IDLE;
   assign io.busy        = state != IDLE;
   assign io.res_valid   = state == RESULT;
   assign io.res_ack     = state == RESULT && ack;
   assign io.res_lost    = state == RESULT && lost;
   assign io.res_biterr  = state == RESULT && bitf;
   assign io.res_timeout = state == RESULT && tmo;
   assign io.res_retries = state == RESULT ? retries : '0;
endmodule
